// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default datapath width and the register-file clear FSM states.
package cpu_pkg;

  localparam int unsigned DataWDefault = 8;

  typedef enum logic [0:0] {
    StIdle,
    StClear
  } clr_state_e;

endpackage

// File: rtl/rf_read_port.sv
// One registered read port of the register file: decode, range/zero check, bypass mux and
// output register. Holds its output when not enabled.
module rf_read_port
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W   = DataWDefault,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned ZERO_REG = 0,
  parameter int unsigned AW       = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  input  logic [DATA_W-1:0] regs [DEPTH],
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rdata
);

  logic [AW-1:0]     idx;
  logic              in_range;
  logic [DATA_W-1:0] rdata_d, rdata_q;

  assign idx      = raddr[AW-1:0];
  assign in_range = (32'(idx) < DEPTH) && !((ZERO_REG != 0) && (idx == '0));

  // The write landing on this edge wins over the array so the port never returns stale data.
  always_comb begin
    rdata_d = '0;
    if (in_range) begin
      if (wr_en && (wr_addr == idx)) begin
        rdata_d = wr_data;
      end else begin
        rdata_d = regs[idx];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/reg_file_2r1w.sv
// Register file with one write port, two registered read ports with write bypass, and a
// one-register-per-cycle clear sweep.
module reg_file_2r1w
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W   = DataWDefault,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re_a,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic              re_b,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  input  logic              clr_start,
  output logic              busy
);

  localparam int unsigned AW = $clog2(DEPTH);

  clr_state_e        state_d, state_q;
  logic [AW-1:0]     cnt_d, cnt_q;
  logic [DATA_W-1:0] regs_q [DEPTH];

  logic [AW-1:0]     widx;
  logic              waddr_ok;
  logic              port_we;
  logic              sweep;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DATA_W-1:0] wr_data;

  assign widx     = waddr[AW-1:0];
  assign waddr_ok = (32'(widx) < DEPTH) && !((ZERO_REG != 0) && (widx == '0));
  assign port_we  = we && (state_q == StIdle) && waddr_ok;
  assign sweep    = (state_q == StClear);

  // Port writes only happen in idle and sweep writes only in clear, so one merged write
  // path feeds both the array and the read-port bypass.
  assign wr_en   = port_we || sweep;
  assign wr_addr = sweep ? cnt_q : widx;
  assign wr_data = sweep ? '0 : wdata;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (clr_start) begin
          state_d = StClear;
          cnt_d   = '0;
        end
      end
      StClear: begin
        if (32'(cnt_q) == DEPTH - 1) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  assign busy = (state_q == StClear);

  rf_read_port #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG),
    .AW       (AW)
  ) u_port_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .re      (re_a),
    .raddr   (raddr_a),
    .regs    (regs_q),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rdata   (rdata_a)
  );

  rf_read_port #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG),
    .AW       (AW)
  ) u_port_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .re      (re_b),
    .raddr   (raddr_b),
    .regs    (regs_q),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rdata   (rdata_b)
  );

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Randomised bench for reg_file_2r1w: a 16-entry instance and a 12-entry zero-register
// instance share stimulus and are each checked against an array model every cycle.
module tb_reg_file_2r1w;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       we, re_a, re_b, clr_start;
  logic [7:0] waddr, wdata, raddr_a, raddr_b;
  logic [7:0] rdata_a [2];
  logic [7:0] rdata_b [2];
  logic       busy [2];

  int n_chk  = 0;
  int n_pass = 0;

  // Model state per instance: 0 = DEPTH 16, 1 = DEPTH 12 with ZERO_REG.
  int         depth [2] = '{16, 12};
  int         zreg  [2] = '{0, 1};
  logic [7:0] m_r   [2][16];
  logic [7:0] m_a   [2];
  logic [7:0] m_b   [2];
  logic       m_busy[2];
  int         m_cnt [2];
  string      nm    [2] = '{"d16", "d12"};

  always #5 clk = ~clk;

  reg_file_2r1w u_d16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .re_a      (re_a),
    .raddr_a   (raddr_a),
    .rdata_a   (rdata_a[0]),
    .re_b      (re_b),
    .raddr_b   (raddr_b),
    .rdata_b   (rdata_b[0]),
    .clr_start (clr_start),
    .busy      (busy[0])
  );

  reg_file_2r1w #(
    .DEPTH    (12),
    .ZERO_REG (1)
  ) u_d12 (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .re_a      (re_a),
    .raddr_a   (raddr_a),
    .rdata_a   (rdata_a[1]),
    .re_b      (re_b),
    .raddr_b   (raddr_b),
    .rdata_b   (rdata_b[1]),
    .clr_start (clr_start),
    .busy      (busy[1])
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 16; i++) m_r[k][i] = 8'h00;
      m_a[k] = 8'h00;
      m_b[k] = 8'h00;
      m_busy[k] = 1'b0;
      m_cnt[k] = 0;
    end
  endtask

  function automatic logic [7:0] model_read(input int k, input int a, input bit wok,
                                            input int wa, input bit sw, input int sa);
    if (a >= depth[k] || (zreg[k] != 0 && a == 0)) return 8'h00;
    if (wok && wa == a) return wdata;
    if (sw && sa == a) return 8'h00;
    return m_r[k][a];
  endfunction

  // Applies the current inputs to the model as one rising edge.
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      int  wa = int'(waddr);
      bit  wok = we && !m_busy[k] && wa < depth[k] && !(zreg[k] != 0 && wa == 0);
      bit  sw = m_busy[k];
      int  sa = m_cnt[k];
      if (re_a) m_a[k] = model_read(k, int'(raddr_a), wok, wa, sw, sa);
      if (re_b) m_b[k] = model_read(k, int'(raddr_b), wok, wa, sw, sa);
      if (wok) m_r[k][wa] = wdata;
      if (sw) begin
        m_r[k][sa] = 8'h00;
        if (sa == depth[k] - 1) m_busy[k] = 1'b0;
        else m_cnt[k] = sa + 1;
      end else if (clr_start) begin
        m_busy[k] = 1'b1;
        m_cnt[k] = 0;
      end
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      check({nm[k], " rdata_a"}, rdata_a[k], m_a[k]);
      check({nm[k], " rdata_b"}, rdata_b[k], m_b[k]);
      check({nm[k], " busy"}, {7'd0, busy[k]}, {7'd0, m_busy[k]});
    end
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
    @(negedge clk);
  endtask

  task automatic drive(input logic w, input logic [7:0] wa, input logic [7:0] wd,
                       input logic ra, input logic [7:0] aa, input logic rb,
                       input logic [7:0] ab, input logic cs);
    we = w; waddr = wa; wdata = wd;
    re_a = ra; raddr_a = aa; re_b = rb; raddr_b = ab; clr_start = cs;
  endtask

  // Asynchronous reset between edges; outputs must clear without a clock.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int busy_cnt [2];
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #1;
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Fill with 0xA5, then reset mid-cycle.
    for (int i = 0; i < 16; i++) begin
      drive(1, 8'(i), 8'hA5, 0, 0, 0, 0, 0);
      step();
    end
    async_reset();
    check("reset busy", {7'd0, busy[0]}, 8'h00);
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, 0, 1, 8'(i), 1, 8'(15 - i), 0);
      step();
      check("post-reset read", rdata_a[0], 8'h00);
    end

    // Write then read on both ports; port A holds when disabled.
    drive(1, 8'd3, 8'h3C, 0, 0, 0, 0, 0);
    step();
    drive(1, 8'd15, 8'hF0, 0, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 1, 8'd3, 1, 8'd15, 0);
    step();
    check("read R3 a", rdata_a[0], 8'h3C);
    check("read R15 b", rdata_b[0], 8'hF0);
    check("d12 read R15 out of range", rdata_b[1], 8'h00);
    drive(0, 0, 0, 0, 8'd5, 1, 8'd3, 0);
    step();
    check("rdata_a hold", rdata_a[0], 8'h3C);

    // Same-edge write and reads at address 7.
    drive(1, 8'd7, 8'h77, 1, 8'd7, 1, 8'd7, 0);
    step();
    check("bypass a", rdata_a[0], 8'h77);
    check("bypass b", rdata_b[0], 8'h77);
    check("d12 bypass a", rdata_a[1], 8'h77);

    // Bounds and the zero register.
    drive(1, 8'd13, 8'h99, 0, 0, 0, 0, 0);
    step();
    drive(1, 8'd0, 8'h55, 0, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 1, 8'd13, 1, 8'd0, 0);
    step();
    check("d12 read addr 13", rdata_a[1], 8'h00);
    check("d12 read R0", rdata_b[1], 8'h00);
    check("d16 read R13", rdata_a[0], 8'h99);
    check("d16 read R0", rdata_b[0], 8'h55);

    // Clear sweep with writes attempted and a second clr_start mid-sweep.
    for (int i = 0; i < 16; i++) begin
      drive(1, 8'(i), 8'($urandom_range(1, 255)), 0, 0, 0, 0, 0);
      step();
    end
    busy_cnt = '{0, 0};
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    for (int c = 0; c < 24; c++) begin
      step();
      for (int k = 0; k < 2; k++) if (busy[k]) busy_cnt[k]++;
      drive(c < 15, 8'($urandom_range(0, 15)), 8'($urandom), 1, 8'($urandom_range(0, 15)),
            1, 8'($urandom_range(0, 15)), c == 4);
    end
    check("d16 busy cycles", 8'(busy_cnt[0]), 8'd16);
    check("d12 busy cycles", 8'(busy_cnt[1]), 8'd12);
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, 0, 1, 8'(i), 1, 8'(i), 0);
      step();
      check("d16 cleared", rdata_a[0], 8'h00);
    end

    // Reset during sweep cycle 5, then normal operation.
    for (int i = 0; i < 16; i++) begin
      drive(1, 8'(i), 8'hC3, 0, 0, 0, 0, 0);
      step();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    step();
    drive(0, 0, 0, 1, 8'd9, 0, 0, 0);
    for (int c = 0; c < 5; c++) step();
    async_reset();
    check("mid-sweep reset busy", {7'd0, busy[0]}, 8'h00);
    drive(1, 8'd9, 8'h5A, 0, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 1, 8'd9, 1, 8'd9, 0);
    step();
    check("R9 after reset a", rdata_a[0], 8'h5A);
    check("d12 R9 after reset b", rdata_b[1], 8'h5A);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      drive(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom),
            1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)),
            $urandom_range(0, 39) == 0);
      if ($urandom_range(0, 499) == 0) async_reset();
      else step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
